braille_chord_capture: RTL and testbench

Upstream input stage for the Braille translator. Samples six raw, bouncing Braille dot keys, synchronizes and debounces them, and accumulates a chord from first key-down until every key is released. On full release it presents the captured cell on registered dot outputs `A`–`F` with a one-cycle `cell_valid` strobe. The dot outputs drive the existing Braille-to-ASCII/7-segment stage directly and hold steady between chords.

---
 rtl/braille_chord_capture_if.sv | 17 +
 rtl/braille_chord_capture.sv | 111 +++++++++++
 tb/tb_braille_chord_capture.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/braille_chord_capture_if.sv
// Key inputs and decoded dot outputs of the Braille chord capture stage.
interface braille_chord_capture_if;
  logic [5:0] key_in;
  logic       A, B, C, D, E, F;
  logic       cell_valid;
  logic       busy;

  modport master (
    output key_in,
    input  A, B, C, D, E, F, cell_valid, busy
  );

  modport slave (
    input  key_in,
    output A, B, C, D, E, F, cell_valid, busy
  );
endinterface

// File: rtl/braille_chord_capture.sv
// Braille chord capture: sync + whole-vector debounce of six dot keys, then
// accumulate a chord from first press to full release and emit it on A..F.
module braille_chord_capture #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  braille_chord_capture_if.slave bus
);
  // Counter only ever reaches DEBOUNCE_CYCLES-1, so clog2 bits never wrap.
  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  state_t        state, state_nxt;
  logic [5:0]    sync1, sync, deb;
  logic [5:0]    chord, chord_nxt, dots;
  logic [CW-1:0] cnt;
  logic          emit_go, cell_valid_q;

  // Two-flop synchronizer per key bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync  <= '0;
    end else begin
      sync1 <= bus.key_in;
      sync  <= sync1;
    end
  end

  // Stability counter over the whole vector. sync1 is the value sync takes
  // next, so a mismatch clears the count on the same edge sync changes.
  // deb is accepted once the count has saturated, i.e. after
  // DEBOUNCE_CYCLES identical samples of sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      deb <= '0;
    end else begin
      if (sync1 != sync)     cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
      if (cnt == CNT_MAX)    deb <= sync;
    end
  end

  // FSM state and chord accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      chord <= '0;
    end else begin
      state <= state_nxt;
      chord <= chord_nxt;
    end
  end

  // Next-state and chord update; emit_go marks the ACCUM->EMIT transition.
  always_comb begin
    state_nxt = state;
    chord_nxt = chord;
    emit_go   = 1'b0;
    case (state)
      IDLE: begin
        chord_nxt = '0;
        if (deb != '0) begin
          state_nxt = ACCUM;
          chord_nxt = deb;
        end
      end
      ACCUM: begin
        if (deb != '0) begin
          chord_nxt = chord | deb;
        end else begin
          state_nxt = EMIT;
          emit_go   = 1'b1;
        end
      end
      EMIT: begin
        state_nxt = IDLE;
        chord_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        chord_nxt = '0;
      end
    endcase
  end

  // Dot outputs land on the edge entering EMIT so they are visible in the
  // EMIT cycle together with the strobe; they hold until the next chord.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dots         <= '0;
      cell_valid_q <= 1'b0;
    end else begin
      cell_valid_q <= emit_go;
      if (emit_go) dots <= chord;
    end
  end

  assign bus.A          = dots[5];
  assign bus.B          = dots[4];
  assign bus.C          = dots[3];
  assign bus.D          = dots[2];
  assign bus.E          = dots[1];
  assign bus.F          = dots[0];
  assign bus.cell_valid = cell_valid_q;
  assign bus.busy       = (state == ACCUM);
endmodule

// File: tb/tb_braille_chord_capture.sv
// Bench for braille_chord_capture: directed test-plan scenarios plus random
// bouncing chords, every cycle compared against a behavioural model.
module tb_braille_chord_capture;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  braille_chord_capture_if bus();

  braille_chord_capture #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  string scen = "init";

  // Model state: raw key history, accepted key vector, chord in progress.
  logic [5:0] m_q[$];
  logic [5:0] m_deb, m_acc, m_dots;
  logic       m_in, m_dead, m_valid;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s observed=%0h expected=%0h", scen, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int j = 0; j <= DB; j++) m_q.push_front(6'd0);
    m_deb = '0; m_acc = '0; m_dots = '0;
    m_in = 1'b0; m_dead = 1'b0; m_valid = 1'b0;
  endtask

  // One rising edge. The chord logic sees the accepted vector from before
  // the edge. A vector is accepted when the raw keys were unchanged for DB
  // samples, ending two samples ago (synchronizer delay).
  task automatic model_step(input logic [5:0] k);
    logic stable;
    m_valid = 1'b0;
    if (m_in) begin
      if (m_deb != 0) m_acc = m_acc | m_deb;
      else begin
        m_valid = 1'b1; m_dots = m_acc; m_acc = '0;
        m_in = 1'b0; m_dead = 1'b1;
      end
    end else if (m_dead) m_dead = 1'b0;
    else if (m_deb != 0) begin
      m_in = 1'b1; m_acc = m_deb;
    end
    stable = 1'b1;
    for (int j = 1; j <= DB; j++) if (m_q[j] != m_q[1]) stable = 1'b0;
    if (stable) m_deb = m_q[1];
    m_q.push_front(k);
    while (m_q.size() > DB + 1) void'(m_q.pop_back());
  endtask

  function automatic logic [5:0] dots_obs();
    return {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F};
  endfunction

  task automatic check_all();
    chk("cell_valid", 8'(bus.cell_valid), 8'(m_valid));
    chk("busy", 8'(bus.busy), 8'(m_in));
    chk("dots", 8'(dots_obs()), 8'(m_dots));
  endtask

  task automatic tick(input logic [5:0] k);
    bus.key_in = k;
    @(posedge clk);
    model_step(k);
    #1;
    if (bus.cell_valid) pulses++;
    check_all();
  endtask

  task automatic ticks(input logic [5:0] k, input int n);
    for (int i = 0; i < n; i++) tick(k);
  endtask

  // One-cycle asynchronous reset pulse, asserted away from the clock edge.
  task automatic reset_pulse();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_dots", 8'(dots_obs()), 8'd0);
    chk("rst_valid", 8'(bus.cell_valid), 8'd0);
    chk("rst_busy", 8'(bus.busy), 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int p0;
    logic [5:0] base, extra, want;
    int hold;

    // 1: reset held with all keys down
    scen = "reset";
    bus.key_in = 6'b111111;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_dots", 8'(dots_obs()), 8'd0);
      chk("rst_valid", 8'(bus.cell_valid), 8'd0);
      chk("rst_busy", 8'(bus.busy), 8'd0);
    end
    bus.key_in = 6'd0;
    rst_n = 1'b1;
    ticks(6'd0, 5);

    // 2: clean two-key chord with absolute timing
    scen = "clean";
    p0 = pulses;
    for (int i = 1; i <= 20; i++) begin
      tick(6'b110000);
      if (i == 6) chk("busy_early", 8'(bus.busy), 8'd0);
      if (i == 7) chk("busy_at7", 8'(bus.busy), 8'd1);
    end
    for (int i = 1; i <= 20; i++) begin
      tick(6'd0);
      if (i == 6) chk("valid_early", 8'(bus.cell_valid), 8'd0);
      if (i == 7) begin
        chk("valid_at7", 8'(bus.cell_valid), 8'd1);
        chk("dots_at7", 8'(dots_obs()), 8'h30);
        chk("busy_fall", 8'(bus.busy), 8'd0);
      end
    end
    ticks(6'd0, 50);
    chk("npulse", 8'(pulses - p0), 8'd1);
    chk("hold", 8'(dots_obs()), 8'h30);

    // 3: bounce on bit 2
    scen = "bounce";
    p0 = pulses;
    tick(6'b000100); tick(6'd0); tick(6'b000100);
    ticks(6'b000100, 20);
    ticks(6'd0, 20);
    chk("npulse", 8'(pulses - p0), 8'd1);
    chk("dots", 8'(dots_obs()), 8'h04);

    // 4: rolling chord, busy must never drop before the pulse
    scen = "rolling";
    p0 = pulses;
    ticks(6'b100000, 10);
    ticks(6'b100100, 10);
    ticks(6'b000100, 10);
    hold = 0;
    for (int i = 0; i < 25; i++) begin
      tick(6'd0);
      if (bus.busy) hold++;
    end
    chk("npulse", 8'(pulses - p0), 8'd1);
    chk("dots", 8'(dots_obs()), 8'h24);
    chk("busy_len", 8'(hold), 8'd6);

    // 5: 2-cycle glitch on bit 0
    scen = "glitch";
    p0 = pulses;
    ticks(6'b000001, 2);
    hold = 0;
    for (int i = 0; i < 20; i++) begin
      tick(6'd0);
      if (bus.busy) hold++;
    end
    chk("npulse", 8'(pulses - p0), 8'd0);
    chk("busy_cnt", 8'(hold), 8'd0);
    chk("dots", 8'(dots_obs()), 8'h24);

    // 6: reset in the middle of a chord while keys stay held
    scen = "midreset";
    ticks(6'b000100, 10);
    ticks(6'd0, 15);
    chk("pre_dots", 8'(dots_obs()), 8'h04);
    p0 = pulses;
    ticks(6'b101000, 12);
    reset_pulse();
    ticks(6'b101000, 15);
    ticks(6'd0, 20);
    chk("npulse", 8'(pulses - p0), 8'd1);
    chk("dots", 8'(dots_obs()), 8'h28);

    // Random chords with bounce on press and release plus rolled-in keys
    scen = "random";
    for (int n = 0; n < 12; n++) begin
      p0 = pulses;
      base = 6'($urandom_range(1, 63));
      extra = 6'($urandom_range(0, 63));
      want = base;
      for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
        tick(base); tick(6'd0);
      end
      hold = int'($urandom_range(6, 14));
      ticks(base, hold);
      if (extra != 0 && $urandom_range(0, 1) == 1) begin
        ticks(base | extra, int'($urandom_range(5, 10)));
        want = base | extra;
        if ($urandom_range(0, 1) == 1) ticks(extra, int'($urandom_range(5, 10)));
      end
      for (int b = 0; b < int'($urandom_range(0, 2)); b++) begin
        tick(6'd0); tick(base);
      end
      ticks(6'd0, int'($urandom_range(12, 20)));
      chk("npulse", 8'(pulses - p0), 8'd1);
      chk("dots", 8'(dots_obs()), 8'(want));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
